// File: rtl/serial_divisibility_scheduler_if.sv
// Handshake bundle for serial_divisibility_scheduler: two operand requesters in, one result out.
// The master modport is the requester/consumer side and the slave modport is the scheduler.
interface serial_divisibility_scheduler_if #(parameter int W = 16);
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         res_valid;
  logic         res_id;
  logic         res_div3;
  logic         res_div5;
  logic         res_div7;
  logic         res_ready;
  logic         busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready,
    input  req0_ready, req1_ready, res_valid, res_id, res_div3, res_div5, res_div7, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready,
    output req0_ready, req1_ready, res_valid, res_id, res_div3, res_div5, res_div7, busy
  );
endinterface

// File: rtl/serial_divisibility_scheduler.sv
// Round-robin two-requester scheduler that tests one operand at a time, MSB-first, for divisibility by 3/5/7.
// Define SERIAL_DIV_MOD7_EN to build the mod-7 residue; otherwise res_div7 is tied low.
module serial_divisibility_scheduler #(
  parameter int W = 16
) (
  input logic                            clk,
  input logic                            rst,
  serial_divisibility_scheduler_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e         state_q,     state_d;
  logic [W-1:0]   shreg_q,     shreg_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [1:0]     r3_q,        r3_d;
  logic [2:0]     r5_q,        r5_d;
  logic           id_q,        id_d;
  logic           last_id_q,   last_id_d;
  logic           res_valid_q, res_valid_d;
  logic           res_id_q,    res_id_d;
  logic           res_div3_q,  res_div3_d;
  logic           res_div5_q,  res_div5_d;
`ifdef SERIAL_DIV_MOD7_EN
  logic [2:0]     r7_q,        r7_d;
  logic [2:0]     r7_step;
  logic           res_div7_q,  res_div7_d;
`endif

  logic       grant0, grant1, bit_in;
  logic [1:0] r3_step;
  logic [2:0] r5_step;

  // (2r+b) never reaches twice the modulus, so one conditional subtract keeps r < m.
  function automatic logic [1:0] step3(input logic [1:0] r, input logic b);
    logic [2:0] t;
    t = {r, b};
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

  function automatic logic [2:0] step5(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

`ifdef SERIAL_DIV_MOD7_EN
  function automatic logic [2:0] step7(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'd7) t = t - 4'd7;
    return t[2:0];
  endfunction

  assign r7_step = step7(r7_q, bit_in);
`endif

  assign bit_in  = shreg_q[W-1];
  assign r3_step = step3(r3_q, bit_in);
  assign r5_step = step5(r5_q, bit_in);

  // On a tie the requester that was not served last wins.
  assign grant0 = (state_q == S_IDLE) && bus.req0_valid && (!bus.req1_valid ||  last_id_q);
  assign grant1 = (state_q == S_IDLE) && bus.req1_valid && (!bus.req0_valid || !last_id_q);

  always_comb begin
    // NOTE: every _d starts as its _q so no branch leaves a variable unassigned (no latch).
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    r3_d        = r3_q;
    r5_d        = r5_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_div3_d  = res_div3_q;
    res_div5_d  = res_div5_q;
`ifdef SERIAL_DIV_MOD7_EN
    r7_d        = r7_q;
    res_div7_d  = res_div7_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          shreg_d   = grant1 ? bus.req1_data : bus.req0_data;
          cnt_d     = CW'(W);
          r3_d      = '0;
          r5_d      = '0;
`ifdef SERIAL_DIV_MOD7_EN
          r7_d      = '0;
`endif
          id_d      = grant1;
          last_id_d = grant1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        r3_d    = r3_step;
        r5_d    = r5_step;
`ifdef SERIAL_DIV_MOD7_EN
        r7_d    = r7_step;
`endif
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_div3_d  = (r3_step == 2'd0);
          res_div5_d  = (r5_step == 3'd0);
`ifdef SERIAL_DIV_MOD7_EN
          res_div7_d  = (r7_step == 3'd0);
`endif
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          res_id_d    = 1'b0;
          res_div3_d  = 1'b0;
          res_div5_d  = 1'b0;
`ifdef SERIAL_DIV_MOD7_EN
          res_div7_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      r3_q        <= '0;
      r5_q        <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_div3_q  <= 1'b0;
      res_div5_q  <= 1'b0;
`ifdef SERIAL_DIV_MOD7_EN
      r7_q        <= '0;
      res_div7_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      r3_q        <= r3_d;
      r5_q        <= r5_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_div3_q  <= res_div3_d;
      res_div5_q  <= res_div5_d;
`ifdef SERIAL_DIV_MOD7_EN
      r7_q        <= r7_d;
      res_div7_q  <= res_div7_d;
`endif
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_div3   = res_div3_q;
  assign bus.res_div5   = res_div5_q;
`ifdef SERIAL_DIV_MOD7_EN
  assign bus.res_div7   = res_div7_q;
`else
  assign bus.res_div7   = 1'b0;
`endif

endmodule
